uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin packet arbiter that shares the UART transmit FIFO write port among several message producers in the comm_clk domain: PONG replies, PARSE/SEND responses, and asynchronous reports such as NONCE_FOUND. A requester is granted the FIFO for a whole packet. The arbiter pops the requester's bytes and writes them to the FIFO without interleaving, so packets from different producers never mix on tx_serial.

## Interface
- NUM_SRC, 3: number of requesters, 2..8; source 0 is conventionally PONG.
- comm_clk  in  1  clock (16x baud domain)
- reset_n  in  1  asynchronous active-low reset
- src_req  in  NUM_SRC  per-source packet request; level, held until matching src_done
- src_len  in  8*NUM_SRC  per-source packet length in bytes, slice i = [8i+7:8i]; sampled at grant
- src_data  in  8*NUM_SRC  per-source current byte; valid while that source is granted
- src_pop  out  NUM_SRC  combinational one-hot; source i advances to its next byte at the next edge
- src_grant  out  NUM_SRC  registered one-hot of the current owner; 0 when idle
- src_done  out  NUM_SRC  registered one-cycle pulse after the last byte of source i is written
- tx_full  in  1  FIFO almost-full; must assert with at least 1 free entry remaining
- tx_we  out  1  registered FIFO write strobe
- tx_data  out  8  registered FIFO write byte

## Operation
- State machine has two states: IDLE and SEND.
- IDLE:
  - Arbitrate among src_req using rr_ptr. The search order is rr_ptr, rr_ptr+1, … mod NUM_SRC; the first set bit wins (g).
  - On a win, register src_grant <= 1<<g, cnt <= src_len[g], rr_ptr <= (g+1) mod NUM_SRC, and go to SEND.
  - If src_len[g]==0, do not enter SEND. Pulse src_done[g] next cycle, advance rr_ptr, and stay in IDLE. No bytes are written.
- SEND, per cycle:
  - If !tx_full: src_pop[g]=1, tx_we<=1, tx_data<=src_data[g], cnt<=cnt-1.
  - If tx_full: no pop, tx_we<=0, and cnt holds.
  - On the write with cnt==1: clear src_grant, pulse src_done[g], and go to IDLE.
- cnt is 8 bits, so packets are 1..255 bytes. There is no wrap; cnt is never decremented below 1 in SEND.
- src_req deasserting mid-packet is ignored: the packet completes with the full length.
- src_len and src_data of non-granted sources are don't-care. src_len[g] changing after grant is ignored.
- Only the granted source ever sees src_pop. At most one src_pop bit is set per cycle.

## Timing
- Reset (asynchronous, reset_n low): state=IDLE, rr_ptr=0, cnt=0, src_grant=0, src_done=0, tx_we=0, tx_data=0, and src_pop=0 (combinational, since state=IDLE).
- Reset mid-packet abandons the packet. No src_done is produced; the source must re-request.
- Grant latency: a request seen in IDLE at cycle t gives src_grant at t+1. The first pop is at t+1, with tx_we/tx_data at t+2.
- Throughput is 1 byte/cycle while !tx_full. The last write with tx_we high is at cycle L+1 after grant (no stalls), with src_done high at the same cycle as that tx_we.
- There is one mandatory IDLE cycle between packets, so the minimum packet-to-packet gap is 1 cycle without tx_we.
- The earliest re-arbitration is the cycle after src_done. A source still requesting then is served only after other pending sources (round-robin).
- tx_full is sampled in the same cycle as the pop decision. The one-cycle registered write lag is covered by the almost-full margin.

## Test plan
- Single PONG: src_req[0]=1, src_len[0]=1, src_data[0]=8'h01. Expect src_grant=001 at t+1, src_pop[0] at t+1, tx_we with tx_data=01 at t+2, src_done[0] at t+2, and no further writes.
- Round-robin: sources 0, 1 and 2 request simultaneously with lengths 2, 3, 2 and data streams A0,A1 / B0,B1,B2 / C0,C1. Expect the FIFO sequence A0 A1 B0 B1 B2 C0 C1 with no interleaving, and rr_ptr back at 0 afterward.
- Fairness: source 1 re-requests immediately after its done while source 2 is pending. Expect source 2 served before source 1's second packet.
- Backpressure: an 8-byte packet from source 2 with tx_full high on bytes 3–5 for 4 cycles. Expect no tx_we and no pop while full, all 8 bytes written in order exactly once, and src_done after the 8th byte.
- Zero length: src_len[1]=0. Expect src_done[1] pulse, zero writes, and no src_pop.
- Reset mid-packet: reset_n low during byte 2 of a 5-byte packet. Expect all outputs 0 immediately and no src_done. After release, a re-request restarts from grant with rr_ptr=0 priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin packet arbiter sharing the UART transmit FIFO write port
//   among NUM_SRC message producers (source 0 is conventionally PONG).
//   A source is granted for a whole packet. Its bytes are popped and
//   written back-to-back, so packets from different producers never
//   interleave on the serial line.
//
// Ports
//   comm_clk   clock (16x baud domain)
//   reset_n    asynchronous active-low reset
//   src_req    per-source packet request (level, held until src_done)
//   src_len    per-source packet length, slice i = [8i+7:8i], sampled at grant
//   src_data   per-source current byte, valid while that source is granted
//   src_pop    combinational one-hot: granted source advances at next edge
//   src_grant  registered one-hot of the current owner, 0 when idle
//   src_done   registered one-cycle pulse after a source's last byte
//   tx_full    FIFO almost-full (at least one free entry remains)
//   tx_we      registered FIFO write strobe
//   tx_data    registered FIFO write byte
module uart_tx_arbiter #(
  parameter int NUM_SRC = 3
) (
  input  logic                 comm_clk,
  input  logic                 reset_n,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_len,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]   src_pop,
  output logic [NUM_SRC-1:0]   src_grant,
  output logic [NUM_SRC-1:0]   src_done,
  input  logic                 tx_full,
  output logic                 tx_we,
  output logic [7:0]           tx_data
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     cur_idx;
  logic [7:0]           cnt;

  logic [NUM_SRC-1:0]   req_eff;
  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  logic [IDX_W-1:0]     rot_off;
  logic [IDX_W:0]       idx_sum;
  logic                 win;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     ptr_after_win;
  logic [NUM_SRC-1:0]   win_onehot;
  logic [7:0]           win_len;
  logic [7:0]           cur_byte;
  logic                 write_ok;
  logic                 last_write;

  // Round-robin search. A source whose done pulse is on this cycle still
  // holds its request (it drops it only after seeing done), so it is masked
  // here; otherwise it would be re-granted a phantom packet.
  always_comb begin
    req_eff = src_req & ~src_done;
    req_dbl = {req_eff, req_eff} >> rr_ptr;
    req_rot = req_dbl[NUM_SRC-1:0];
    win     = 1'b0;
    rot_off = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win     = 1'b1;
        rot_off = IDX_W'(k);
      end
    end
    idx_sum = {1'b0, rr_ptr} + {1'b0, rot_off};
    if (idx_sum >= (IDX_W+1)'(NUM_SRC)) begin
      idx_sum = idx_sum - (IDX_W+1)'(NUM_SRC);
    end
    win_idx       = idx_sum[IDX_W-1:0];
    ptr_after_win = (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
  end

  assign win_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    win_len = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (win_idx == IDX_W'(k)) win_len = src_len[8*k +: 8];
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (cur_idx == IDX_W'(k)) cur_byte = src_data[8*k +: 8];
    end
  end

  // tx_full is looked at in the same cycle as the pop; the registered write
  // lands one cycle later and is absorbed by the almost-full margin.
  assign write_ok   = (state == SEND) && !tx_full;
  assign last_write = write_ok && (cnt == 8'd1);

  // State register
  always_ff @(posedge comm_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a zero-length packet never leaves IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win && (win_len != 8'd0)) state_nxt = SEND;
      SEND:    if (last_write)               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: only the owner is popped, and only when the FIFO has room
  always_comb begin
    src_pop = '0;
    if (write_ok) src_pop = src_grant;
  end

  // Registered grant / count / write path
  always_ff @(posedge comm_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      cur_idx   <= '0;
      cnt       <= '0;
      src_grant <= '0;
      src_done  <= '0;
      tx_we     <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_we    <= 1'b0;
      src_done <= '0;
      case (state)
        IDLE: begin
          if (win) begin
            rr_ptr  <= ptr_after_win;
            cnt     <= win_len;
            cur_idx <= win_idx;
            if (win_len != 8'd0) src_grant <= win_onehot;
            else                 src_done  <= win_onehot;
          end
        end
        SEND: begin
          if (write_ok) begin
            tx_we   <= 1'b1;
            tx_data <= cur_byte;
            cnt     <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              src_grant <= '0;
              src_done  <= src_grant;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
